// File: rtl/branch_logic_if.sv
// Operand/flag/result bundle between the decode stage and the BranchL branch-resolution unit.
// The master drives the opcode, operands and flags; the slave returns the taken flag and the target.
interface branch_if #(
   parameter int OPW  = 6,
   parameter int OFSW = 26,
   parameter int DW   = 32
);
   logic [OPW-1:0]  opcode;
   logic [OFSW-1:0] offset_in;
   logic [DW-1:0]   rs_value;
   logic            zflag_ff;
   logic            oflag_ff;
   logic            cflag_ff;
   logic            sflag_ff;
   logic [OFSW-1:0] offset_out;
   logic            branch;

   modport master (
      output opcode, offset_in, rs_value, zflag_ff, oflag_ff, cflag_ff, sflag_ff,
      input  offset_out, branch
   );

   modport slave (
      input  opcode, offset_in, rs_value, zflag_ff, oflag_ff, cflag_ff, sflag_ff,
      output offset_out, branch
   );
endinterface

// File: rtl/branch_logic.sv
// BranchL: decodes the branch opcode against the registered ALU flags, with one-cycle registered outputs.
// Define BRANCHL_RS_COMPARE_EN to enable the rs-versus-zero compares (opcodes 10..13).
module branch_logic #(
   parameter int OPW  = 6,
   parameter int OFSW = 26,
   parameter int DW   = 32
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   branch_if.slave  bus
);

   logic            taken_s;
   logic [OFSW-1:0] target_s;
   logic            branch_d;
   logic            branch_q;
   logic [OFSW-1:0] offset_d;
   logic [OFSW-1:0] offset_q;

`ifndef BRANCHL_RS_COMPARE_EN
   logic unused_rs_hi_s;
   assign unused_rs_hi_s = ^bus.rs_value[DW-1:OFSW];
`endif

   // Taken decision and target selection; only the flag named by the opcode is examined.
   always_comb begin
      taken_s  = 1'b0;
      target_s = bus.offset_in;
      case (bus.opcode)
         6'd0:    taken_s = 1'b1;
         6'd1:    taken_s = bus.zflag_ff;
         6'd2:    taken_s = ~bus.zflag_ff;
         6'd3: begin
            taken_s  = 1'b1;
            target_s = bus.rs_value[OFSW-1:0];
         end
         6'd4:    taken_s = bus.cflag_ff;
         6'd5:    taken_s = ~bus.cflag_ff;
         6'd6:    taken_s = bus.sflag_ff;
         6'd7:    taken_s = ~bus.sflag_ff;
         6'd8:    taken_s = bus.oflag_ff;
         6'd9:    taken_s = ~bus.oflag_ff;
`ifdef BRANCHL_RS_COMPARE_EN
         6'd10:   taken_s = bus.rs_value[DW-1];
         6'd11:   taken_s = ~bus.rs_value[DW-1];
         6'd12:   taken_s = (bus.rs_value == {DW{1'b0}});
         6'd13:   taken_s = (bus.rs_value != {DW{1'b0}});
`endif
         default: taken_s = 1'b0;
      endcase
   end

   // A not-taken decision clears the offset so no stale target reaches the PC logic.
   always_comb begin
      branch_d = taken_s;
      if (taken_s) begin
         offset_d = target_s;
      end else begin
         offset_d = {OFSW{1'b0}};
      end
   end

   // Output registers; asynchronous clear holds both outputs low while reset is asserted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         branch_q <= 1'b0;
         offset_q <= {OFSW{1'b0}};
      end else begin
         branch_q <= branch_d;
         offset_q <= offset_d;
      end
   end

   assign bus.branch     = branch_q;
   assign bus.offset_out = offset_q;

endmodule

// File: tb/tb_branch_logic.sv
// Scoreboard bench for branch_logic: a driver pushes reference results, a monitor pops and compares them.
// Honours BRANCHL_RS_COMPARE_EN in the reference model so both builds are checked.
module tb_branch_logic;

   typedef struct {
      logic        b;
      logic [25:0] off;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   exp_t sb_q[$];

   branch_if bif ();

   branch_logic dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: flag-select/polarity tables plus signed arithmetic for the rs compares.
   function automatic exp_t model(input logic [5:0] op, input logic [25:0] off, input logic [31:0] rs,
                                  input logic z, input logic o, input logic c, input logic s);
      int   flag_of [0:9] = '{0, 0, 0, 0, 2, 2, 3, 3, 1, 1};
      bit   want_set[0:9] = '{1, 1, 0, 1, 1, 0, 1, 0, 1, 0};
      logic [3:0] flags;
      bit   cond;
      logic [25:0] tgt;
      exp_t r;
      flags = {s, c, o, z};
      tgt   = off;
      cond  = 1'b0;
      if (op == 6'd0) begin
         cond = 1'b1;
      end else if (op == 6'd3) begin
         cond = 1'b1;
         tgt  = rs[25:0];
      end else if (op <= 6'd9) begin
         cond = (flags[flag_of[op]] == want_set[op]);
      end else if (op <= 6'd13) begin
`ifdef BRANCHL_RS_COMPARE_EN
         if (op == 6'd10) cond = ($signed(rs) < 0);
         else if (op == 6'd11) cond = ($signed(rs) >= 0);
         else if (op == 6'd12) cond = (rs == 32'd0);
         else cond = (rs != 32'd0);
`else
         cond = 1'b0;
`endif
      end
      r.b   = cond;
      r.off = cond ? tgt : 26'd0;
      return r;
   endfunction

   task automatic drive(input logic [5:0] op, input logic [25:0] off, input logic [31:0] rs,
                        input logic z, input logic o, input logic c, input logic s);
      @(negedge clk);
      bif.opcode    = op;
      bif.offset_in = off;
      bif.rs_value  = rs;
      bif.zflag_ff  = z;
      bif.oflag_ff  = o;
      bif.cflag_ff  = c;
      bif.sflag_ff  = s;
      sb_q.push_back(model(op, off, rs, z, o, c, s));
   endtask

   task automatic check_out(input string name, input logic b_exp, input logic [25:0] off_exp);
      n_cmp++;
      if (bif.branch !== b_exp || bif.offset_out !== off_exp) begin
         n_bad++;
         $display("FAIL %s: got branch=%0b offset=%h, expected branch=%0b offset=%h",
                  name, bif.branch, bif.offset_out, b_exp, off_exp);
      end
   endtask

   // Monitor: every registered result after reset release is matched against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_out("scoreboard", e.b, e.off);
         end
      end
   end

   initial begin
      logic [5:0]  r_op;
      logic [25:0] r_off;
      logic [31:0] r_rs;
      logic [3:0]  r_fl;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bif.opcode = 6'd0; bif.offset_in = 26'd0; bif.rs_value = 32'd0;
      bif.zflag_ff = 1'b0; bif.oflag_ff = 1'b0; bif.cflag_ff = 1'b0; bif.sflag_ff = 1'b0;
      @(posedge clk); #1;
      check_out("reset_state", 1'b0, 26'd0);
      @(negedge clk);
      rst_n = 1'b1;

      drive(6'd1, 26'd4, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(6'd2, 26'd4, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(6'd4, 26'd8, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(6'd7, 26'd8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(6'd9, 26'd8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(6'd3, 26'd7, 32'hFC00_0010, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(6'd10, 26'd5, 32'hFFFF_FFE0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(6'd13, 26'd20, 32'd16, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(6'd12, 26'd6, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(6'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(6'd0, 26'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(6'd20, 26'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      check_out("hold_until_posedge", 1'b1, 26'd9);

      // Mid-run reset with a taken branch on the inputs.
      @(negedge clk);
      bif.opcode = 6'd0; bif.offset_in = 26'd5;
      rst_n = 1'b0;
      #1;
      check_out("reset_immediate", 1'b0, 26'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check_out("reset_held", 1'b0, 26'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(6'd0, 26'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         r_op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(14, 63)) : 6'($urandom_range(0, 13));
         r_off = 26'($urandom);
         r_rs  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         r_fl  = 4'($urandom);
         drive(r_op, r_off, r_rs, r_fl[0], r_fl[1], r_fl[2], r_fl[3]);
      end

      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
